// File: rtl/core8_mem_arbiter2.sv
// Two-master Avalon-MM arbiter in front of a single-port on-chip RAM with a fixed
// one-cycle read latency. Contention alternates between masters; reads return in issue order.
module core8_mem_arbiter2 #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    // Handshake: a master's access completes in the cycle it requests with waitrequest=0.
    logic req0;
    logic req1;
    logic grant0;
    logic grant1;
    logic last_grant;
    logic rd_vld;
    logic rd_own;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // last_grant=1 means master 1 won most recently, so master 0 takes the next tie.
    assign grant0 = req0 & (~req1 | last_grant);
    assign grant1 = req1 & ~grant0;

    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;

    assign mem_address    = grant1 ? m1_address    : m0_address;
    assign mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = grant0 | grant1;
    assign mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rd_vld     <= 1'b0;
            rd_own     <= 1'b0;
        end else begin
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
            // Read+write together is a write, so only a pure read enters the return slot.
            rd_vld <= (grant0 & ~m0_write) | (grant1 & ~m1_write);
            rd_own <= grant1;
        end
    end

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_vld & ~rd_own;
    assign m1_readdatavalid = rd_vld & rd_own;

endmodule

// File: tb/tb_core8_mem_arbiter2.sv
// Bench for core8_mem_arbiter2: behavioural RAM plus a reference model of arbitration,
// memory contents and read returns, driven by directed scenarios and random traffic.
module tb_core8_mem_arbiter2;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read, m1_read, m0_write, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;

    core8_mem_arbiter2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // On-chip RAM: registered read, one cycle of latency, byte-lane writes.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_q;
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
            ram_q <= ram[mem_address];
        end
    end
    assign mem_readdata = ram_q;

    // Reference model state.
    int               checks = 0;
    int               errors = 0;
    int               prev_winner = 1;
    logic [31:0]      mdl_mem [int];
    logic [DATA_W:0]  exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdl_read(input int a);
        if (mdl_mem.exists(a)) return mdl_mem[a];
        return 32'h0;
    endfunction

    task automatic mdl_write(input int a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] w;
        w = mdl_read(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        mdl_mem[a] = w;
    endtask

    // Evaluated mid-cycle: checks returns due now, predicts the grant, then advances the model.
    task automatic model_step();
        int win;
        logic [DATA_W:0] e;
        logic r0, r1, wr;
        int a;
        logic [3:0] be;
        logic [31:0] wd;
        if (!reset_n) begin
            exp_q.delete();
            prev_winner = 1;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rdv0", m0_readdatavalid, !e[DATA_W]);
            check_eq("rdv1", m1_readdatavalid, e[DATA_W]);
            check_eq("rdata0", m0_readdata, e[DATA_W-1:0]);
            check_eq("rdata1", m1_readdata, e[DATA_W-1:0]);
        end else begin
            check_eq("rdv0_idle", m0_readdatavalid, 0);
            check_eq("rdv1_idle", m1_readdatavalid, 0);
        end
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (r0 && r1)  win = 1 - prev_winner;
        else if (r0)   win = 0;
        else if (r1)   win = 1;
        else           win = -1;
        check_eq("wait0", m0_waitrequest, win != 0);
        check_eq("wait1", m1_waitrequest, win != 1);
        check_eq("chipselect", mem_chipselect, win >= 0);
        check_eq("mem_write", mem_write, (win == 0) ? m0_write : (win == 1) ? m1_write : 1'b0);
        check_eq("mem_addr", mem_address, (win == 1) ? m1_address : m0_address);
        check_eq("mem_be", mem_byteenable, (win == 1) ? m1_byteenable : m0_byteenable);
        check_eq("mem_wd", mem_writedata, (win == 1) ? m1_writedata : m0_writedata);
        check_eq("clken", mem_clken, 1);
        if (win >= 0) begin
            wr = (win == 1) ? m1_write : m0_write;
            a  = int'((win == 1) ? m1_address : m0_address);
            be = (win == 1) ? m1_byteenable : m0_byteenable;
            wd = (win == 1) ? m1_writedata : m0_writedata;
            if (wr) mdl_write(a, be, wd);
            else if (reset_n) exp_q.push_back({win == 1, mdl_read(a)});
            if (reset_n) prev_winner = win;
        end
    endtask

    task automatic do_cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic rd, input logic wr, input int a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = ADDR_W'(a);
            m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = ADDR_W'(a);
            m1_byteenable = be; m1_writedata = wd;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 0, 4'h0, 32'h0);
        drive(1, 0, 0, 0, 4'h0, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_all();
        do_cycle();
        do_cycle();
        reset_n = 1'b1;

        // Both masters read from the first cycle after reset: m0 wins first, then alternate.
        drive(0, 1, 0, 1, 4'hF, 32'h0);
        drive(1, 1, 0, 2, 4'hF, 32'h0);
        repeat (4) do_cycle();
        idle_all();
        do_cycle();

        // Full-word write then read-back by the same master.
        drive(0, 0, 1, 16, 4'hF, 32'hDEADBEEF); do_cycle();
        drive(0, 1, 0, 16, 4'hF, 32'h0);        do_cycle();
        idle_all(); do_cycle();

        // Partial byte-enable write over an existing word.
        drive(1, 0, 1, 32, 4'hF, 32'hAAAAAAAA); do_cycle();
        drive(1, 0, 1, 32, 4'h3, 32'h11223344); do_cycle();
        idle_all();
        drive(0, 1, 0, 32, 4'hF, 32'h0);        do_cycle();
        idle_all(); do_cycle();

        // Read and write asserted together act as a write only.
        drive(1, 1, 1, 48, 4'hF, 32'h5); do_cycle();
        drive(1, 1, 0, 48, 4'hF, 32'h0); do_cycle();
        idle_all(); do_cycle();

        // Streaming reads from a single master.
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, i, 4'hF, 32'h0);
            do_cycle();
        end
        idle_all(); do_cycle();

        // Reset lands while a read return is in flight.
        drive(0, 1, 0, 16, 4'hF, 32'h0); do_cycle();
        idle_all();
        reset_n = 1'b0; do_cycle();
        reset_n = 1'b1; do_cycle();
        drive(0, 1, 0, 1, 4'hF, 32'h0);
        drive(1, 1, 0, 2, 4'hF, 32'h0);
        do_cycle();
        idle_all(); do_cycle();

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < 2; m++) begin
                drive(m, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                      int'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom);
            end
            reset_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            do_cycle();
        end
        reset_n = 1'b1;
        idle_all();
        do_cycle();
        do_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
